// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings and the slot records used by the command-to-bus master.
package ahb_lite_master_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_e;

   // Address-phase slot: err marks a misaligned command that never reaches the bus.
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic        err;
   } ap_slot_t;

   typedef struct packed {
      logic        write;
      logic        err;
      logic [31:0] wdata;
   } dp_slot_t;

endpackage

// File: rtl/ahb_size_lane.sv
// Combinational alignment check and write-lane replication for one incoming command.
module ahb_size_lane
   import ahb_lite_master_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  size,
   input  logic [31:0] wdata,
   output logic        misaligned,
   output logic [31:0] wdata_lanes
);

   always_comb begin
      misaligned  = 1'b0;
      wdata_lanes = wdata;
      case (size)
         HSIZE_BYTE: wdata_lanes = {4{wdata[7:0]}};
         HSIZE_HALF: begin
            misaligned  = addr_lo[0];
            wdata_lanes = {2{wdata[15:0]}};
         end
         HSIZE_WORD: misaligned = |addr_lo;
         default:    misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding-command AHB-Lite master with one address-phase and one data-phase slot.
// Define AHB_MASTER_PIPE_EN to let a new address phase overlap the previous data phase.
module ahb_lite_master
   import ahb_lite_master_pkg::*;
#(
   parameter int STALL_W = 16
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic               CMD_VALID,
   output logic               CMD_READY,
   input  logic [31:0]        CMD_ADDR,
   input  logic               CMD_WRITE,
   input  logic [2:0]         CMD_SIZE,
   input  logic [31:0]        CMD_WDATA,
   output logic               RSP_VALID,
   output logic [31:0]        RSP_RDATA,
   output logic               RSP_ERR,
   output logic [31:0]        HADDR,
   output logic [1:0]         HTRANS,
   output logic [2:0]         HSIZE,
   output logic               HWRITE,
   output logic [31:0]        HWDATA,
   input  logic [31:0]        HRDATA,
   input  logic               HREADY,
   output logic [STALL_W-1:0] STALL_CNT
);

   localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

   ap_slot_t            ap_q, ap_d;
   logic                ap_valid_q, ap_valid_d;
   dp_slot_t            dp_q, dp_d;
   logic                dp_valid_q, dp_valid_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic                cmd_misaligned;
   logic [31:0]         cmd_wdata_lanes;
   logic                cmd_fire;
   logic                ap_advance;
   logic                dp_complete;

   ahb_size_lane u_size_lane (
      .addr_lo     (CMD_ADDR[1:0]),
      .size        (CMD_SIZE),
      .wdata       (CMD_WDATA),
      .misaligned  (cmd_misaligned),
      .wdata_lanes (cmd_wdata_lanes)
   );

   // Readiness looks only at slot state and HREADY, never at the command inputs.
`ifdef AHB_MASTER_PIPE_EN
   assign CMD_READY = HRESETn & (~ap_valid_q | HREADY);
`else
   assign CMD_READY = HRESETn & ~ap_valid_q & ~dp_valid_q;
`endif

   assign cmd_fire    = CMD_VALID & CMD_READY;
   assign ap_advance  = ap_valid_q & HREADY;
   assign dp_complete = dp_valid_q & HREADY;

   always_comb begin
      ap_valid_d  = ap_valid_q;
      ap_d        = ap_q;
      dp_valid_d  = dp_valid_q;
      dp_d        = dp_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      stall_cnt_d = stall_cnt_q;

      if (dp_complete) begin
         dp_valid_d  = 1'b0;
         rsp_valid_d = 1'b1;
         rsp_err_d   = dp_q.err;
         rsp_rdata_d = (dp_q.write | dp_q.err) ? 32'h0 : HRDATA;
      end

      // HREADY high also retires any data phase, so DP is always free when AP moves.
      if (ap_advance) begin
         ap_valid_d = 1'b0;
         dp_valid_d = 1'b1;
         dp_d.write = ap_q.write;
         dp_d.err   = ap_q.err;
         if (ap_q.write & ~ap_q.err) begin
            dp_d.wdata = ap_q.wdata;
         end
      end

      if (cmd_fire) begin
         ap_valid_d = 1'b1;
         ap_d.addr  = CMD_ADDR;
         ap_d.write = CMD_WRITE;
         ap_d.size  = CMD_SIZE;
         ap_d.wdata = cmd_wdata_lanes;
         ap_d.err   = cmd_misaligned;
      end

      if (dp_valid_q & ~HREADY & ~(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + STALL_ONE;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ap_valid_q  <= 1'b0;
         ap_q        <= '0;
         dp_valid_q  <= 1'b0;
         dp_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
         stall_cnt_q <= '0;
      end else begin
         ap_valid_q  <= ap_valid_d;
         ap_q        <= ap_d;
         dp_valid_q  <= dp_valid_d;
         dp_q        <= dp_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Misaligned commands occupy AP but present IDLE so the slave never sees them.
   assign HTRANS    = (ap_valid_q & ~ap_q.err) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR     = ap_q.addr;
   assign HSIZE     = ap_q.size;
   assign HWRITE    = ap_q.write;
   assign HWDATA    = dp_q.wdata;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_RDATA = rsp_rdata_q;
   assign RSP_ERR   = rsp_err_q;
   assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: directed scenarios plus randomized traffic against a bus-level reference model.
`timescale 1ns/1ps
module tb_ahb_lite_master;

   localparam int STALL_W   = 3;
   localparam int STALL_MAX = (1 << STALL_W) - 1;

   logic               HCLK = 1'b0;
   logic               HRESETn;
   logic               CMD_VALID;
   logic               CMD_READY;
   logic [31:0]        CMD_ADDR;
   logic               CMD_WRITE;
   logic [2:0]         CMD_SIZE;
   logic [31:0]        CMD_WDATA;
   logic               RSP_VALID;
   logic [31:0]        RSP_RDATA;
   logic               RSP_ERR;
   logic [31:0]        HADDR;
   logic [1:0]         HTRANS;
   logic [2:0]         HSIZE;
   logic               HWRITE;
   logic [31:0]        HWDATA;
   logic [31:0]        HRDATA;
   logic               HREADY;
   logic [STALL_W-1:0] STALL_CNT;

   always #5 HCLK = ~HCLK;

   ahb_lite_master #(.STALL_W(STALL_W)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR),
      .CMD_WRITE(CMD_WRITE), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .STALL_CNT(STALL_CNT)
   );

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic        mis;
   } cmd_t;

   cmd_t        rsp_q[$];
   cmd_t        bus_q[$];
   logic [31:0] rd_q[$];
   logic [32:0] rsp_log[$];
   int          ap_cyc[$];
   cmd_t        mc;
   cmd_t        dp_cmd;
   bit          dp_pend;
   logic [31:0] exp_rd;
   int          cyc;
   int          n_cmp;
   int          n_mis;
   int          rand_mode;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit is_mis(input logic [2:0] size, input logic [31:0] addr);
      return (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] lanes(input logic [2:0] size, input logic [31:0] d);
      if (size == 3'd0) return 32'h0101_0101 * {24'h0, d[7:0]};
      if (size == 3'd1) return 32'h0001_0001 * {16'h0, d[15:0]};
      return d;
   endfunction

   // Reference model: every accepted command owes one in-order response; aligned ones
   // must appear as a NONSEQ address phase followed by a data phase.
   always @(negedge HCLK) begin
      cyc++;
      if (!HRESETn) begin
         rsp_q.delete();
         bus_q.delete();
         rd_q.delete();
         dp_pend = 1'b0;
      end else begin
         if (RSP_VALID) begin
            rsp_log.push_back({RSP_ERR, RSP_RDATA});
            if (rsp_q.size() == 0) begin
               chk("rsp_extra", 1, 0);
            end else begin
               mc = rsp_q.pop_front();
               if (mc.mis) begin
                  chk("rsp_err_mis", RSP_ERR, 1);
                  chk("rsp_rdata_mis", RSP_RDATA, 0);
               end else if (mc.wr) begin
                  chk("rsp_err_wr", RSP_ERR, 0);
                  chk("rsp_rdata_wr", RSP_RDATA, 0);
               end else begin
                  chk("rsp_err_rd", RSP_ERR, 0);
                  if (rd_q.size() == 0) begin
                     chk("rd_data_missing", 1, 0);
                  end else begin
                     exp_rd = rd_q.pop_front();
                     chk("rsp_rdata_rd", RSP_RDATA, exp_rd);
                  end
               end
            end
         end
         if (dp_pend && HREADY) begin
            if (dp_cmd.wr) chk("hwdata", HWDATA, lanes(dp_cmd.size, dp_cmd.wdata));
            else rd_q.push_back(HRDATA);
            dp_pend = 1'b0;
         end
         if (HTRANS == 2'b10) begin
            if (bus_q.size() == 0) begin
               chk("unexpected_nonseq", 1, 0);
            end else begin
               chk("haddr", HADDR, bus_q[0].addr);
               chk("hsize", HSIZE, bus_q[0].size);
               chk("hwrite", HWRITE, bus_q[0].wr);
               if (HREADY) begin
                  dp_cmd  = bus_q.pop_front();
                  dp_pend = 1'b1;
                  ap_cyc.push_back(cyc);
               end
            end
         end else begin
            chk("htrans_idle", HTRANS, 0);
         end
         if (CMD_VALID && CMD_READY) begin
            mc.addr  = CMD_ADDR;
            mc.wr    = CMD_WRITE;
            mc.size  = CMD_SIZE;
            mc.wdata = CMD_WDATA;
            mc.mis   = is_mis(CMD_SIZE, CMD_ADDR);
            rsp_q.push_back(mc);
            if (!mc.mis) bus_q.push_back(mc);
         end
      end
   end

   always @(posedge HCLK) begin
      #1;
      if (rand_mode >= 1) HRDATA = $urandom;
      if (rand_mode == 2) HREADY = ($urandom_range(0, 3) != 0);
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
      bit got;
      got       = 1'b0;
      CMD_VALID = 1'b1;
      CMD_ADDR  = a;
      CMD_WRITE = w;
      CMD_SIZE  = s;
      CMD_WDATA = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge HCLK);
         if (CMD_READY) begin
            got = 1'b1;
            break;
         end
      end
      tick();
      CMD_VALID = 1'b0;
      if (!got) chk("accept_timeout", 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_htrans"}, HTRANS, 0);
      chk({tag, "_haddr"}, HADDR, 0);
      chk({tag, "_hsize"}, HSIZE, 0);
      chk({tag, "_hwrite"}, HWRITE, 0);
      chk({tag, "_hwdata"}, HWDATA, 0);
      chk({tag, "_rsp_valid"}, RSP_VALID, 0);
      chk({tag, "_rsp_rdata"}, RSP_RDATA, 0);
      chk({tag, "_rsp_err"}, RSP_ERR, 0);
      chk({tag, "_stall_cnt"}, STALL_CNT, 0);
      chk({tag, "_cmd_ready"}, CMD_READY, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [2:0]  sz;
      n_cmp = 0; n_mis = 0; cyc = 0; rand_mode = 0; dp_pend = 1'b0;
      HRESETn = 1'b0; CMD_VALID = 1'b0; CMD_ADDR = 32'h0; CMD_WRITE = 1'b0;
      CMD_SIZE = 3'd0; CMD_WDATA = 32'h0; HRDATA = 32'h0; HREADY = 1'b1;

      repeat (2) @(negedge HCLK);
      check_reset_outputs("por");
      tick();
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("por_ready_release", CMD_READY, 1);
      tick();

      // Zero-wait word write
      send_cmd(32'h6000_0010, 1'b1, 3'd2, 32'hA5A5_1234);
      @(negedge HCLK);
      chk("wr_htrans_ap", HTRANS, 2'b10);
      chk("wr_haddr", HADDR, 32'h6000_0010);
      chk("wr_hwrite", HWRITE, 1);
      @(negedge HCLK);
      chk("wr_htrans_dp", HTRANS, 2'b00);
      chk("wr_hwdata", HWDATA, 32'hA5A5_1234);
      chk("wr_rsp_early", RSP_VALID, 0);
      @(negedge HCLK);
      chk("wr_rsp_valid", RSP_VALID, 1);
      chk("wr_rsp_err", RSP_ERR, 0);
      tick();

      // Byte write replicated across lanes
      send_cmd(32'h4800_0003, 1'b1, 3'd0, 32'h0000_005A);
      @(negedge HCLK);
      chk("byte_hsize", HSIZE, 3'b000);
      chk("byte_htrans", HTRANS, 2'b10);
      @(negedge HCLK);
      chk("byte_hwdata", HWDATA, 32'h5A5A_5A5A);
      repeat (2) tick();

      // Reset in the middle of a stalled read
      send_cmd(32'h4000_0020, 1'b0, 3'd2, 32'h0);
      tick();
      HREADY = 1'b0;
      repeat (2) tick();
      HRESETn = 1'b0;
      @(negedge HCLK);
      check_reset_outputs("midrst");
      HREADY = 1'b1;
      repeat (2) tick();
      HRESETn = 1'b1;
      rsp_log.delete();
      @(negedge HCLK);
      chk("midrst_ready_release", CMD_READY, 1);
      chk("midrst_htrans", HTRANS, 2'b00);
      repeat (4) @(negedge HCLK);
      chk("midrst_no_rsp", rsp_log.size(), 0);
      tick();

      // Read with three wait states
      send_cmd(32'h4000_0004, 1'b0, 3'd2, 32'h0);
      tick();
      HREADY = 1'b0;
      HRDATA = 32'hCAFE_0001;
      repeat (3) tick();
      HREADY = 1'b1;
      @(negedge HCLK);
      @(negedge HCLK);
      chk("rd3_rsp_valid", RSP_VALID, 1);
      chk("rd3_rsp_rdata", RSP_RDATA, 32'hCAFE_0001);
      chk("rd3_stall_cnt", STALL_CNT, 3);
      HRDATA = 32'h0;
      @(negedge HCLK);
      chk("rd3_rdata_hold", RSP_RDATA, 32'hCAFE_0001);
      tick();

      // Five more wait states push the counter past its ceiling
      send_cmd(32'h4000_0008, 1'b0, 3'd2, 32'h0);
      tick();
      HREADY = 1'b0;
      HRDATA = 32'h0BAD_F00D;
      repeat (5) tick();
      HREADY = 1'b1;
      repeat (2) @(negedge HCLK);
      chk("stall_saturate", STALL_CNT, (3 + 5 > STALL_MAX) ? STALL_MAX : 3 + 5);
      tick();

      // Back-to-back reads
      rand_mode = 1;
      ap_cyc.delete();
      rsp_log.delete();
      send_cmd(32'h4000_0040, 1'b0, 3'd2, 32'h0);
      send_cmd(32'h4000_0044, 1'b0, 3'd2, 32'h0);
      repeat (6) @(negedge HCLK);
      chk("b2b_nonseq_count", ap_cyc.size(), 2);
      chk("b2b_rsp_count", rsp_log.size(), 2);
      if (ap_cyc.size() == 2) begin
`ifdef AHB_MASTER_PIPE_EN
         chk("b2b_gap_pipe", ap_cyc[1] - ap_cyc[0], 1);
`else
         chk("b2b_idle_gap", (ap_cyc[1] - ap_cyc[0]) >= 2, 1);
`endif
      end
      rand_mode = 0;
      tick();

      // Misaligned halfword queued behind a stalled read
      HREADY = 1'b1;
      HRDATA = 32'h0;
      ap_cyc.delete();
      rsp_log.delete();
      send_cmd(32'h4000_0100, 1'b0, 3'd2, 32'h0);
      fork
         begin
            tick();
            HREADY = 1'b0;
            repeat (3) tick();
            HRDATA = 32'h1357_9BDF;
            HREADY = 1'b1;
         end
         send_cmd(32'h6000_0001, 1'b0, 3'd1, 32'h0);
      join
      repeat (8) @(negedge HCLK);
      chk("mis_nonseq_count", ap_cyc.size(), 1);
      chk("mis_rsp_count", rsp_log.size(), 2);
      if (rsp_log.size() == 2) begin
         chk("mis_first_err", rsp_log[0][32], 0);
         chk("mis_first_rdata", rsp_log[0][31:0], 32'h1357_9BDF);
         chk("mis_second_err", rsp_log[1][32], 1);
         chk("mis_second_rdata", rsp_log[1][31:0], 0);
      end
      tick();

      // Randomized traffic with random wait states
      rand_mode = 2;
      for (int i = 0; i < 80; i++) begin
         sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         a  = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         send_cmd(a, 1'($urandom_range(0, 1)), sz, $urandom);
         repeat ($urandom_range(0, 2)) tick();
      end
      for (int i = 0; i < 500; i++) begin
         @(negedge HCLK);
         if (rsp_q.size() == 0) break;
      end
      chk("drain_rsp_q", rsp_q.size(), 0);
      chk("drain_bus_q", bus_q.size(), 0);
      rand_mode = 0;
      tick();
      HREADY = 1'b1;
      repeat (3) @(negedge HCLK);
      chk("final_idle", HTRANS, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter STALL_W, default 16, the width of the saturating stall counter.
REQ-002 SHALL have port HCLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port HRESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have CMD_VALID, input, 1 bit, and CMD_READY, output, 1 bit: the command handshake; a command transfers on a rising edge with both high.
REQ-005 SHALL have the command payload inputs CMD_ADDR (32), CMD_WRITE (1), CMD_SIZE (3, HSIZE encoding) and CMD_WDATA (32).
REQ-006 SHALL have response outputs RSP_VALID (1, one-cycle pulse, no backpressure), RSP_RDATA (32) and RSP_ERR (1).
REQ-007 SHALL have AHB-Lite master outputs HADDR (32), HTRANS (2), HSIZE (3), HWRITE (1) and HWDATA (32).
REQ-008 SHALL have AHB-Lite master inputs HRDATA (32) and HREADY (1).
REQ-009 SHALL have output STALL_CNT, STALL_W bits: count of data-phase cycles with HREADY low.

Function
REQ-010 SHALL hold one address-phase slot (AP) and one data-phase slot (DP), each valid or empty.
REQ-011 SHALL register an accepted command into AP on the acceptance edge; HADDR, HSIZE, HWRITE and HTRANS=NONSEQ (2'b10) SHALL be driven from AP from the next cycle.
REQ-012 SHALL hold AP outputs stable while HREADY=0; on an edge with AP valid and HREADY=1, AP SHALL move to DP.
REQ-013 SHALL drive HTRANS=IDLE (2'b00) whenever AP is empty; HADDR, HSIZE and HWRITE keep their last values.
REQ-014 SHALL drive HWDATA during DP with the write data replicated across lanes: a byte x4, a halfword x2, a word as is; HWDATA SHALL hold until DP completes.
REQ-015 SHALL complete DP on an edge with DP valid and HREADY=1, then pulse RSP_VALID for the next cycle.
REQ-016 SHALL set RSP_RDATA to HRDATA sampled at DP completion for reads, and to 0 for writes; RSP_RDATA SHALL hold until the next response.
REQ-017 SHALL treat a command as misaligned when CMD_SIZE>2, or CMD_SIZE=1 with ADDR[0]=1, or CMD_SIZE=2 with ADDR[1:0]!=0.
REQ-018 SHALL accept misaligned commands and route them through AP/DP with HTRANS=IDLE, producing RSP_ERR=1 and RSP_RDATA=0; this keeps responses in order.
REQ-019 SHALL keep RSP_ERR=0 for aligned commands.
REQ-020 SHALL increment STALL_CNT on every cycle with DP valid and HREADY=0, saturating at all-ones.
REQ-021 SHALL guarantee that CMD_READY never depends on CMD_* inputs.

Reset
REQ-022 SHALL, while HRESETn=0, force HTRANS=0, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, STALL_CNT=0, and AP and DP empty.
REQ-023 SHALL, on reset mid-transfer, abandon any in-flight AP/DP transfer with no response pulse.
REQ-024 SHALL hold CMD_READY=0 during reset and assert it on the first cycle after release.

Configuration
REQ-025 SHALL use macro AHB_MASTER_PIPE_EN; when defined, CMD_READY = !AP_valid | HREADY, so a new address phase overlaps the previous data phase with no IDLE gap.
REQ-026 SHALL, without AHB_MASTER_PIPE_EN, set CMD_READY = !AP_valid & !DP_valid, so at least one IDLE cycle separates consecutive NONSEQ transfers.

Structure
REQ-027 SHALL take the HTRANS encodings (IDLE, NONSEQ) and HSIZE encodings (BYTE, HALF, WORD) from constants in the shared AHB utility header, with no local literals.
REQ-028 SHALL place the alignment check and write-lane replication in one combinational sub-module, ahb_size_lane.

Verification
REQ-029 SHALL verify reset: pulse HRESETn low mid-read -> all outputs 0, HTRANS=00, no RSP_VALID, CMD_READY=1 after release.
REQ-030 SHALL verify a zero-wait write: addr 0x6000_0010, data 0xA5A5_1234, size 2, HREADY=1 -> HTRANS=10 for 1 cycle, HWDATA=0xA5A5_1234 the next cycle, RSP_VALID the cycle after, RSP_ERR=0.
REQ-031 SHALL verify a read with 3 wait states: addr 0x4000_0004, HRDATA=0xCAFE_0001 -> RSP_RDATA=0xCAFE_0001 and STALL_CNT=3.
REQ-032 SHALL verify a byte write: 0x5A to 0x4800_0003, size 0 -> HSIZE=000, HWDATA=0x5A5A_5A5A.
REQ-033 SHALL verify two back-to-back reads with HREADY=1 -> with the macro, NONSEQ on consecutive cycles; without it, at least one IDLE cycle between them; responses in order.
REQ-034 SHALL verify a misaligned halfword read at 0x6000_0001 queued behind a stalled read -> no NONSEQ for it, responses in order, second RSP_ERR=1, RSP_RDATA=0.
